// File: rtl/sb_pkg.sv
// Shared sideband definitions: default packet/gap sizing and the TX serializer state type.
package sb_pkg;

  localparam int SB_PKT_W  = 64;
  localparam int SB_GAP_UI = 32;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_SHIFT = 2'd1,
    SB_GAP   = 2'd2
  } sb_tx_state_e;

endpackage

// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: loads one packet word, shifts it out LSB first with a
// gated forwarded clock, then holds a fixed idle gap before the next packet.
//
// Load handshake: a word is taken on a rising edge where i_load_valid and
// o_load_ready are both high. o_load_ready is high only in IDLE and in the last
// GAP cycle; i_load_valid is ignored at any other time, so a held valid is never
// queued.
module sb_tx_serializer
  import sb_pkg::*;
#(
  parameter int DATA_W = SB_PKT_W,
  parameter int GAP_UI = SB_GAP_UI
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_load_ready,
  output logic              o_txdat,
  output logic              o_txclk_en,
  output logic              o_busy,
  output logic              o_pkt_done,
  output sb_tx_state_e      o_state
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [5:0]       GAP_LAST = 6'(GAP_UI - 1);

  sb_tx_state_e      state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_q, bit_d;
  logic [5:0]        gap_q, gap_d;
  logic              accept;
  logic              txdat_d, txclk_en_d, load_ready_d, pkt_done_d;

  assign accept = i_load_valid && o_load_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= SB_IDLE;
      shift_q      <= '0;
      bit_q        <= '0;
      gap_q        <= '0;
      o_txdat      <= 1'b0;
      o_txclk_en   <= 1'b0;
      o_load_ready <= 1'b1;
      o_pkt_done   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
      o_txdat      <= txdat_d;
      o_txclk_en   <= txclk_en_d;
      o_load_ready <= load_ready_d;
      o_pkt_done   <= pkt_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    case (state_q)
      SB_IDLE: begin
        if (accept) begin
          state_d = SB_SHIFT;
          shift_d = i_data;
          bit_d   = '0;
        end
      end
      SB_SHIFT: begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 1'b1;
        if (bit_q == BIT_LAST) begin
          state_d = SB_GAP;
          bit_d   = '0;
          gap_d   = '0;
        end
      end
      SB_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          // Reloading straight from the last gap cycle keeps the gap exactly GAP_UI.
          if (accept) begin
            state_d = SB_SHIFT;
            shift_d = i_data;
            bit_d   = '0;
          end else begin
            state_d = SB_IDLE;
          end
        end
      end
      default: begin
        state_d = SB_IDLE;
        shift_d = '0;
        bit_d   = '0;
        gap_d   = '0;
      end
    endcase
  end

  // Output flops are loaded from next-state values so they line up with state_q.
  always_comb begin
    txdat_d      = 1'b0;
    txclk_en_d   = 1'b0;
    load_ready_d = 1'b0;
    pkt_done_d   = 1'b0;
    case (state_d)
      SB_SHIFT: begin
        txdat_d    = shift_d[0];
        txclk_en_d = 1'b1;
      end
      SB_GAP: begin
        load_ready_d = (gap_d == GAP_LAST);
        pkt_done_d   = (gap_d == GAP_LAST);
      end
      default: load_ready_d = 1'b1;
    endcase
  end

  assign o_busy  = (state_q != SB_IDLE);
  assign o_state = state_q;

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Bench for sb_tx_serializer: a default build and a GAP_UI=1 build share stimulus and
// are checked every cycle against a queue-of-UIs line model.
module tb_sb_tx_serializer;
  import sb_pkg::*;

  localparam int W = 64;
  localparam int G0 = 32;
  localparam int G1 = 1;

  typedef struct packed {
    logic busy;
    logic en;
    logic dat;
    logic done;
  } ui_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         valid = 1'b0;
  logic [W-1:0] data = '0;

  logic rdy0, txd0, en0, busy0, done0;
  logic rdy1, txd1, en1, busy1, done1;
  sb_tx_state_e st0, st1;

  sb_tx_serializer #(.DATA_W(W), .GAP_UI(G0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_valid(valid), .i_data(data),
    .o_load_ready(rdy0), .o_txdat(txd0), .o_txclk_en(en0), .o_busy(busy0),
    .o_pkt_done(done0), .o_state(st0)
  );

  sb_tx_serializer #(.DATA_W(W), .GAP_UI(G1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_valid(valid), .i_data(data),
    .o_load_ready(rdy1), .o_txdat(txd1), .o_txclk_en(en1), .o_busy(busy1),
    .o_pkt_done(done1), .o_state(st1)
  );

  // line model: future UIs per DUT; the current UI is cur[k]; ready when nothing is pending
  ui_t q0[$];
  ui_t q1[$];
  ui_t cur [2];
  logic [6:0] obs [2];
  logic [6:0] exp [2];
  int checks = 0;
  int errors = 0;
  int ncycle = 0;

  function automatic sb_tx_state_e exp_state(input ui_t c);
    if (c.en) return SB_SHIFT;
    if (c.busy) return SB_GAP;
    return SB_IDLE;
  endfunction

  task automatic push_pkt(input int k, input logic [W-1:0] d, input int g);
    ui_t e;
    for (int i = 0; i < W; i++) begin
      e = '{busy: 1'b1, en: 1'b1, dat: d[i], done: 1'b0};
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
    for (int j = 0; j < g; j++) begin
      e = '{busy: 1'b1, en: 1'b0, dat: 1'b0, done: (j == g - 1)};
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    cur[0] = '0;
    cur[1] = '0;
  endtask

  task automatic sample();
    exp[0] = {q0.size() == 0, cur[0], exp_state(cur[0])};
    exp[1] = {q1.size() == 0, cur[1], exp_state(cur[1])};
    obs[0] = {rdy0, busy0, en0, txd0, done0, st0};
    obs[1] = {rdy1, busy1, en1, txd1, done1, st1};
  endtask

  // driver: one clock, model advanced with the inputs presented before the edge
  task automatic cycle();
    logic a0, a1;
    a0 = valid && rst_n && (q0.size() == 0);
    a1 = valid && rst_n && (q1.size() == 0);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (a0) push_pkt(0, data, G0);
      if (a1) push_pkt(1, data, G1);
      if (q0.size() > 0) cur[0] = q0.pop_front(); else cur[0] = '0;
      if (q1.size() > 0) cur[1] = q1.pop_front(); else cur[1] = '0;
    end
    #1;
    ncycle++;
    sample();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      cycle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp[k] || obs[k] !== {5'b10000, SB_IDLE}) begin
          errors++;
          $display("FAIL reset dut%0d cycle %0d: got %b expected %b", k, ncycle, obs[k], exp[k]);
        end
      end
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_load(input string name, input logic [W-1:0] d, input int tail);
    data = d;
    valid = 1'b1;
    cycle();
    valid = 1'b0;
    data = W'($urandom()) ^ (W'($urandom()) << 32);
    for (int c = 0; c < W + G0 + tail; c++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp[k]) begin
          errors++;
          $display("FAIL %s dut%0d cycle %0d: got %b expected %b", name, k, ncycle, obs[k], exp[k]);
        end
      end
      cycle();
    end
  endtask

  task automatic test_back_to_back();
    int lowrun [2];
    int npkt [2];
    int b2 [2];
    logic [1:0] en_v, en_prev, dat_v;
    lowrun = '{0, 0};
    npkt = '{0, 0};
    b2 = '{0, 0};
    en_prev = 2'b00;
    data = 64'h1;
    valid = 1'b1;
    for (int c = 0; c < 2 * W + G0 + 6; c++) begin
      cycle();
      if (ncycle > 0 && en0) data = 64'h8000_0000_0000_0000;
      if (npkt[0] >= 2 && npkt[1] >= 2) valid = 1'b0;
      en_v = {en1, en0};
      dat_v = {txd1, txd0};
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp[k]) begin
          errors++;
          $display("FAIL b2b dut%0d cycle %0d: got %b expected %b", k, ncycle, obs[k], exp[k]);
        end
        if (en_v[k] && !en_prev[k]) begin
          npkt[k]++;
          if (npkt[k] == 2) begin
            checks++;
            if (lowrun[k] !== (k == 0 ? G0 : G1)) begin
              errors++;
              $display("FAIL b2b_gap dut%0d: got %0d low UI expected %0d", k, lowrun[k], (k == 0 ? G0 : G1));
            end
          end
          b2[k] = 0;
        end
        if (en_v[k] && npkt[k] == 2 && data == 64'h8000_0000_0000_0000) begin
          if (b2[k] == 0 || b2[k] == W - 1) begin
            checks++;
            if (dat_v[k] !== (b2[k] == W - 1)) begin
              errors++;
              $display("FAIL b2b_bits dut%0d ui %0d: got %b expected %b", k, b2[k], dat_v[k], (b2[k] == W - 1));
            end
          end
          b2[k]++;
        end
        if (!en_v[k]) lowrun[k]++; else lowrun[k] = 0;
      end
      en_prev = en_v;
    end
    valid = 1'b0;
    for (int c = 0; c < G0 + 4; c++) cycle();
  endtask

  task automatic test_ignore_valid();
    logic [W-1:0] d;
    d = W'($urandom()) ^ (W'($urandom()) << 32);
    data = d;
    valid = 1'b1;
    cycle();
    valid = 1'b0;
    for (int c = 0; c < W + G0 + 4; c++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp[k]) begin
          errors++;
          $display("FAIL ignore dut%0d cycle %0d: got %b expected %b", k, ncycle, obs[k], exp[k]);
        end
      end
      // pulse a competing word while bit 20 is on the line
      valid = (c == 20);
      data = (c == 20) ? ~d : d;
      cycle();
    end
    valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    data = W'($urandom()) ^ (W'($urandom()) << 32);
    valid = 1'b1;
    cycle();
    valid = 1'b0;
    for (int c = 0; c < 40; c++) cycle();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    sample();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp[k]) begin
        errors++;
        $display("FAIL reset_mid dut%0d: got %b expected %b", k, obs[k], exp[k]);
      end
    end
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== {5'b10000, SB_IDLE}) begin
        errors++;
        $display("FAIL reset_release dut%0d: got %b expected %b", k, obs[k], {5'b10000, SB_IDLE});
      end
    end
    test_load("reset_reload", W'($urandom()) ^ (W'($urandom()) << 32), 3);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      valid = ($urandom_range(0, 3) == 0);
      data = W'($urandom()) ^ (W'($urandom()) << 32);
      cycle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp[k]) begin
          errors++;
          $display("FAIL random dut%0d cycle %0d: got %b expected %b", k, ncycle, obs[k], exp[k]);
        end
      end
    end
    valid = 1'b0;
    for (int c = 0; c < W + G0 + 2; c++) cycle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load("single", 64'hA5A5_0000_FFFF_1234, 4);
    test_load("zero", 64'h0, 4);
    test_back_to_back();
    test_ignore_valid();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sb_tx_serializer.md
SB_TX_SERIALIZER -- requirements
Module: sb_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning sideband packet width in bits (UI per packet).
REQ-002 SHALL have parameter GAP_UI, default 32, meaning mandatory low/idle UI count between packets; legal range 1..63.
REQ-003 SHALL have port i_clk  input  1  serial-rate clock, one UI per cycle.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_load_valid  input  1  upstream packet word valid, driven by the TX FSM clock-enable path.
REQ-006 SHALL have port i_data  input  DATA_W  packet word read from the TX FIFO.
REQ-007 SHALL have port o_load_ready  output  1  serializer can accept a word this cycle.
REQ-008 SHALL have port o_txdat  output  1  serial sideband data, LSB first.
REQ-009 SHALL have port o_txclk_en  output  1  forwarded-clock gate; high only while data UIs are driven.
REQ-010 SHALL have port o_busy  output  1  high in SHIFT or GAP.
REQ-011 SHALL have port o_pkt_done  output  1  single-cycle pulse when the final gap UI completes.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, GAP; reset state IDLE.
REQ-013 SHALL assert o_load_ready in IDLE and in the last GAP cycle (gap_cnt == GAP_UI-1); deassert it otherwise.
REQ-014 SHALL accept a word on a rising edge where i_load_valid && o_load_ready; capture i_data into a DATA_W shift register and enter SHIFT.
REQ-015 SHALL drive o_txdat = shift_reg[0] and o_txclk_en = 1 from the cycle after acceptance, for exactly DATA_W consecutive cycles (latency 1 cycle).
REQ-016 SHALL shift right by one each SHIFT cycle, filling with 0; bit counter 0..DATA_W-1, width $clog2(DATA_W).
REQ-017 SHALL leave SHIFT for GAP after the cycle driving bit DATA_W-1.
REQ-018 SHALL drive o_txdat = 0 and o_txclk_en = 0 in IDLE and GAP.
REQ-019 SHALL hold GAP for exactly GAP_UI cycles using a gap counter cleared on GAP entry.
REQ-020 SHALL pulse o_pkt_done high for one cycle in the last GAP cycle.
REQ-021 SHALL, on acceptance in the last GAP cycle, go directly GAP->SHIFT so packets are separated by exactly GAP_UI low UIs.
REQ-022 SHALL return GAP->IDLE when the last GAP cycle has no acceptance.
REQ-023 SHALL ignore i_load_valid while o_load_ready is low; no word is queued or dropped silently because upstream holds valid.
REQ-024 SHALL serialize an all-zero word like any other word; zero filtering is upstream responsibility.
REQ-025 SHALL register o_txdat, o_txclk_en, o_load_ready, o_pkt_done (no combinational path from inputs to outputs).

Reset
REQ-026 SHALL, on i_rst_n low, asynchronously set state IDLE, shift register 0, counters 0, o_txdat 0, o_txclk_en 0, o_pkt_done 0, o_busy 0, o_load_ready 1.
REQ-027 SHALL abort any packet in flight on reset mid-SHIFT/GAP with no further clock-enable UIs after release; the first cycle after release is IDLE.

Structure
REQ-028 SHALL take SB_PKT_W (64) and SB_GAP_UI (32) defaults and the state enum type from the shared sideband package sb_pkg.
REQ-029 SHALL be a single module with no sub-modules; the gap counter and the bit counter MAY share one register.

Verification
REQ-030 Single load i_data=64'hA5A5_0000_FFFF_1234 in IDLE -> o_txdat LSB-first over 64 cycles starting 1 cycle after acceptance, o_txclk_en high exactly 64 cycles, then 32 low, o_pkt_done at cycle 96 after first bit.
REQ-031 Back-to-back: i_load_valid held with 64'h1 then 64'h8000_0000_0000_0000 -> 64 UI, exactly 32 low UI, 64 UI; o_txdat high at UI 0 and at UI 63 of second packet.
REQ-032 i_load_valid pulsed during SHIFT (bit 20) -> ignored, o_load_ready low, no corruption of current packet.
REQ-033 Reset asserted at bit 40 -> o_txclk_en and o_txdat 0 immediately; after release state IDLE, o_load_ready 1, next load serializes cleanly.
REQ-034 i_data=0 load -> 64 UI with o_txclk_en high and o_txdat 0, then 32-UI gap.
REQ-035 GAP_UI=1 build, back-to-back loads -> exactly one low UI between packets.
